// File: rtl/mc_control_fsm_if.sv
// Memory handshake bundle between the main control FSM and the memory port.
interface mc_control_fsm_if;
    logic       mem_req_o;
    logic       mem_ready_i;
    logic [6:0] opcode_i;

    modport master (output mem_req_o, input mem_ready_i, input opcode_i);
    modport slave  (input mem_req_o, output mem_ready_i, output opcode_i);
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main control FSM: handshaked fetch/load/store, wait timeout, trapping.
// Define MC_FSM_PERF_EN to add cycle/instret/wait performance counters.
module mc_control_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4
`ifdef MC_FSM_PERF_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    mc_control_fsm_if.master mem,
    input  logic [6:0]       ir_opcode_i,
    input  logic             stall_i,
    input  logic             trap_ack_i,
    output logic             PCUpdate_o,
    output logic             RegWrite_o,
    output logic             MemWrite_o,
    output logic             IRWrite_o,
    output logic             b_en_o,
    output logic             ALUOP_ow_o,
    output logic [1:0]       ResultSrc_o,
    output logic [1:0]       ALUSrcA_o,
    output logic [1:0]       ALUSrcB_o,
    output logic             trap_o,
    output logic [1:0]       trap_cause_o,
    output logic [4:0]       state_o
`ifdef MC_FSM_PERF_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instret_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o
`endif
);

    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [4:0] {
        FETCH   = 5'd0,
        DECODE  = 5'd1,
        MEM_ADR = 5'd2,
        MEM_RD  = 5'd3,
        MEM_WR  = 5'd4,
        MEM_WB  = 5'd5,
        EXCT_R  = 5'd6,
        EXCT_I  = 5'd7,
        JAL     = 5'd8,
        JALR1   = 5'd9,
        JALR2   = 5'd10,
        LUI     = 5'd11,
        AUIPC   = 5'd12,
        ALU_WB  = 5'd13,
        BQ      = 5'd14,
        TRAP    = 5'd15
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic [1:0]        cause, cause_next;
    logic              mem_req;
    logic              timeout;

    // A request that has waited MAX_WAIT cycles traps unless ready arrives now.
    assign timeout = (MAX_WAIT > 0) && (wait_cnt == WAIT_W'(MAX_WAIT)) && !mem.mem_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state    <= FETCH;
            wait_cnt <= '0;
            cause    <= CAUSE_NONE;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            cause    <= cause_next;
        end
    end

    always_comb begin
        state_next  = state;
        cause_next  = cause;
        mem_req     = 1'b0;
        PCUpdate_o  = 1'b0;
        RegWrite_o  = 1'b0;
        MemWrite_o  = 1'b0;
        IRWrite_o   = 1'b0;
        b_en_o      = 1'b0;
        ALUOP_ow_o  = 1'b0;
        ResultSrc_o = 2'b00;
        ALUSrcA_o   = 2'b00;
        ALUSrcB_o   = 2'b00;
        trap_o      = 1'b0;
        case (state)
            FETCH: begin
                if (!stall_i) begin
                    mem_req     = 1'b1;
                    ALUSrcB_o   = 2'b10;
                    ResultSrc_o = 2'b01;
                    ALUOP_ow_o  = 1'b1;
                    IRWrite_o   = mem.mem_ready_i;
                    PCUpdate_o  = mem.mem_ready_i;
                    if (mem.mem_ready_i) begin
                        state_next = DECODE;
                    end else if (timeout) begin
                        state_next = TRAP;
                        cause_next = CAUSE_TIMEOUT;
                    end
                end
            end
            DECODE: begin
                ALUSrcA_o  = 2'b01;
                ALUSrcB_o  = 2'b01;
                ALUOP_ow_o = 1'b1;
                case (ir_opcode_i)
                    OP_L, OP_S: state_next = MEM_ADR;
                    OP_R:       state_next = EXCT_R;
                    OP_B:       state_next = BQ;
                    OP_I:       state_next = EXCT_I;
                    OP_JAL:     state_next = JAL;
                    OP_JALR:    state_next = JALR1;
                    OP_LUI:     state_next = LUI;
                    OP_AUIPC:   state_next = AUIPC;
                    default: begin
                        state_next = TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEM_ADR: begin
                ALUSrcA_o  = 2'b10;
                ALUSrcB_o  = 2'b01;
                state_next = (ir_opcode_i == OP_S) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                if (mem.mem_ready_i) begin
                    state_next = MEM_WB;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            MEM_WR: begin
                mem_req    = 1'b1;
                MemWrite_o = 1'b1;
                if (mem.mem_ready_i) begin
                    state_next = FETCH;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            MEM_WB: begin
                ResultSrc_o = 2'b11;
                RegWrite_o  = 1'b1;
                state_next  = FETCH;
            end
            EXCT_R: begin
                ALUSrcA_o  = 2'b10;
                state_next = ALU_WB;
            end
            EXCT_I, JALR1: begin
                ALUSrcA_o  = 2'b10;
                ALUSrcB_o  = 2'b01;
                state_next = (state == JALR1) ? JALR2 : ALU_WB;
            end
            JAL, JALR2: begin
                ALUSrcA_o  = 2'b01;
                ALUSrcB_o  = 2'b10;
                PCUpdate_o = 1'b1;
                state_next = ALU_WB;
            end
            LUI: begin
                ResultSrc_o = 2'b10;
                RegWrite_o  = 1'b1;
                state_next  = FETCH;
            end
            AUIPC: begin
                RegWrite_o = 1'b1;
                state_next = FETCH;
            end
            ALU_WB: begin
                RegWrite_o = 1'b1;
                ALUOP_ow_o = 1'b1;
                state_next = FETCH;
            end
            BQ: begin
                b_en_o     = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                trap_o = 1'b1;
                if (trap_ack_i) begin
                    state_next = FETCH;
                    cause_next = CAUSE_NONE;
                end
            end
            default: state_next = FETCH;
        endcase

        // Counter only runs while a request stays pending in the same state.
        if ((state_next != state) || !mem_req || mem.mem_ready_i) begin
            wait_next = '0;
        end else begin
            wait_next = wait_cnt + WAIT_W'(1);
        end
    end

    assign mem.mem_req_o = mem_req;
    assign trap_cause_o  = cause;
    assign state_o       = state;

`ifdef MC_FSM_PERF_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        if (state_next == FETCH) begin
            case (state)
                MEM_WR, MEM_WB, LUI, AUIPC, ALU_WB, BQ: retire = 1'b1;
                default:                                retire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cycle_cnt_o   <= '0;
            instret_cnt_o <= '0;
            wait_cnt_o    <= '0;
        end else begin
            cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
            if (retire) begin
                instret_cnt_o <= instret_cnt_o + CNT_W'(1);
            end
            if (mem_req && !mem.mem_ready_i) begin
                wait_cnt_o <= wait_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomised self-checking bench for mc_control_fsm against an instruction-level model.
module tb_mc_control_fsm;
    localparam int MAXW = 4;

    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [6:0] ir_opcode_i;
    logic       stall_i;
    logic       trap_ack_i;
    logic       PCUpdate_o, RegWrite_o, MemWrite_o, IRWrite_o, b_en_o, ALUOP_ow_o;
    logic [1:0] ResultSrc_o, ALUSrcA_o, ALUSrcB_o;
    logic       trap_o;
    logic [1:0] trap_cause_o;
    logic [4:0] state_o;
`ifdef MC_FSM_PERF_EN
    logic [31:0] cycle_cnt_o, instret_cnt_o, wait_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    int elapsed = 0;
    int exp_instret = 0;
    int exp_wait = 0;

    logic [15:0] DEC, ADR, RD, WR, WB, XR, XI, JMP, JR1, LUIW, AUIW, ALUWB, BQW;
    logic [6:0]  ops [9];

    mc_control_fsm_if mif();

    mc_control_fsm #(.MAX_WAIT(MAXW), .WAIT_W(3)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .mem          (mif),
        .ir_opcode_i  (ir_opcode_i),
        .stall_i      (stall_i),
        .trap_ack_i   (trap_ack_i),
        .PCUpdate_o   (PCUpdate_o),
        .RegWrite_o   (RegWrite_o),
        .MemWrite_o   (MemWrite_o),
        .IRWrite_o    (IRWrite_o),
        .b_en_o       (b_en_o),
        .ALUOP_ow_o   (ALUOP_ow_o),
        .ResultSrc_o  (ResultSrc_o),
        .ALUSrcA_o    (ALUSrcA_o),
        .ALUSrcB_o    (ALUSrcB_o),
        .trap_o       (trap_o),
        .trap_cause_o (trap_cause_o),
        .state_o      (state_o)
`ifdef MC_FSM_PERF_EN
        ,
        .cycle_cnt_o  (cycle_cnt_o),
        .instret_cnt_o(instret_cnt_o),
        .wait_cnt_o   (wait_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Control word: req,pcu,rw,mw,irw,ben,aluop,rs[2],a[2],b[2],trap,cause[2]
    function automatic logic [15:0] w(input logic req, pcu, rw, mw, irw, ben, aop,
                                      input logic [1:0] rs, a, b,
                                      input logic tr, input logic [1:0] c);
        return {req, pcu, rw, mw, irw, ben, aop, rs, a, b, tr, c};
    endfunction

    function automatic logic [15:0] fetch_w(input logic r);
        return w(1, r, 0, 0, r, 0, 1, 2'b01, 2'b00, 2'b10, 0, 2'b00);
    endfunction

    function automatic logic [15:0] trap_w(input logic [1:0] c);
        return w(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, c);
    endfunction

    function automatic logic [15:0] obs();
        return {mif.mem_req_o, PCUpdate_o, RegWrite_o, MemWrite_o, IRWrite_o, b_en_o,
                ALUOP_ow_o, ResultSrc_o, ALUSrcA_o, ALUSrcB_o, trap_o, trap_cause_o};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {OP_L, OP_S, OP_R, OP_B, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    task automatic zero_model();
        elapsed     = 0;
        exp_instret = 0;
        exp_wait    = 0;
    endtask

    task automatic cyc(input logic rdy, input logic st, input logic ack,
                       input logic [15:0] exp, input string tag);
        logic [15:0] got;
        mif.mem_ready_i = rdy;
        stall_i         = st;
        trap_ack_i      = ack;
        @(negedge clk_i);
        got = obs();
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
        if (exp[15] && !rdy) exp_wait++;
        @(posedge clk_i);
        #1;
        elapsed++;
    endtask

    // nw wait cycles then ready; more than MAXW waits means the request times out.
    task automatic req_phase(input int nw, input logic [15:0] wait_w, input logic [15:0] rdy_w,
                             input string tag, input bit rand_stall, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= MAXW; i++) begin
            if (i == nw) begin
                cyc(1'b1, rand_stall ? rb() : 1'b0, 1'b0, rdy_w, tag);
                ok = 1'b1;
                break;
            end
            cyc(1'b0, rand_stall ? rb() : 1'b0, 1'b0, wait_w, tag);
        end
    endtask

    task automatic trap_seq(input logic [1:0] c);
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) cyc(rb(), rb(), 1'b0, trap_w(c), "trap_hold");
        cyc(rb(), rb(), 1'b1, trap_w(c), "trap_ack");
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int nst);
        bit ok;
        ir_opcode_i  = op;
        mif.opcode_i = op;
        for (int i = 0; i < nst; i++) cyc(rb(), 1'b1, 1'b0, 16'h0000, "stall");
        req_phase(fw, fetch_w(1'b0), fetch_w(1'b1), "fetch", 1'b0, ok);
        if (!ok) begin
            trap_seq(2'b10);
            return;
        end
        cyc(rb(), rb(), 1'b0, DEC, "decode");
        case (op)
            OP_L: begin
                cyc(rb(), rb(), 1'b0, ADR, "adr_ld");
                req_phase(mw, RD, RD, "mem_rd", 1'b1, ok);
                if (ok) cyc(rb(), rb(), 1'b0, WB, "mem_wb");
                else trap_seq(2'b10);
            end
            OP_S: begin
                cyc(rb(), rb(), 1'b0, ADR, "adr_st");
                req_phase(mw, WR, WR, "mem_wr", 1'b1, ok);
                if (!ok) trap_seq(2'b10);
            end
            OP_R: begin
                cyc(rb(), rb(), 1'b0, XR, "exct_r");
                cyc(rb(), rb(), 1'b0, ALUWB, "alu_wb_r");
            end
            OP_I: begin
                cyc(rb(), rb(), 1'b0, XI, "exct_i");
                cyc(rb(), rb(), 1'b0, ALUWB, "alu_wb_i");
            end
            OP_JAL: begin
                cyc(rb(), rb(), 1'b0, JMP, "jal");
                cyc(rb(), rb(), 1'b0, ALUWB, "alu_wb_jal");
            end
            OP_JALR: begin
                cyc(rb(), rb(), 1'b0, JR1, "jalr1");
                cyc(rb(), rb(), 1'b0, JMP, "jalr2");
                cyc(rb(), rb(), 1'b0, ALUWB, "alu_wb_jalr");
            end
            OP_LUI:   cyc(rb(), rb(), 1'b0, LUIW, "lui");
            OP_AUIPC: cyc(rb(), rb(), 1'b0, AUIW, "auipc");
            OP_B:     cyc(rb(), rb(), 1'b0, BQW, "bq");
            default: begin
                trap_seq(2'b01);
                ok = 1'b0;
            end
        endcase
        if (ok) exp_instret++;
    endtask

    task automatic perf_check(input string tag);
`ifdef MC_FSM_PERF_EN
        total++;
        assert (cycle_cnt_o === 32'(elapsed)) else begin
            bad++;
            $error("FAIL %s_cycle observed=%0d expected=%0d", tag, cycle_cnt_o, elapsed);
        end
        total++;
        assert (instret_cnt_o === 32'(exp_instret)) else begin
            bad++;
            $error("FAIL %s_instret observed=%0d expected=%0d", tag, instret_cnt_o, exp_instret);
        end
        total++;
        assert (wait_cnt_o === 32'(exp_wait)) else begin
            bad++;
            $error("FAIL %s_wait observed=%0d expected=%0d", tag, wait_cnt_o, exp_wait);
        end
`endif
    endtask

    task automatic reset_mid_write();
        bit ok;
        ir_opcode_i  = OP_S;
        mif.opcode_i = OP_S;
        req_phase(0, fetch_w(1'b0), fetch_w(1'b1), "rst_fetch", 1'b0, ok);
        cyc(rb(), rb(), 1'b0, DEC, "rst_decode");
        cyc(rb(), rb(), 1'b0, ADR, "rst_adr");
        cyc(1'b0, 1'b0, 1'b0, WR, "rst_wr_wait");
        cyc(1'b0, 1'b0, 1'b0, WR, "rst_wr_wait");
        rstn_i = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, WR, "rst_wr_edge");
        rstn_i = 1'b1;
        zero_model();
        for (int i = 0; i < 5; i++) cyc(rb(), 1'b1, 1'b0, 16'h0000, "rst_stalled");
    endtask

    initial begin
        DEC   = w(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 2'b00);
        ADR   = w(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00);
        RD    = w(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        WR    = w(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        WB    = w(0, 0, 1, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 2'b00);
        XR    = w(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b00);
        XI    = w(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00);
        JMP   = w(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00);
        JR1   = w(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00);
        LUIW  = w(0, 0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 2'b00);
        AUIW  = w(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        ALUWB = w(0, 0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        BQW   = w(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00);
        ops   = '{OP_L, OP_S, OP_R, OP_B, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        rstn_i          = 1'b0;
        stall_i         = 1'b0;
        trap_ack_i      = 1'b0;
        mif.mem_ready_i = 1'b0;
        ir_opcode_i     = OP_R;
        mif.opcode_i    = OP_R;
        @(posedge clk_i);
        #1;
        cyc(1'b0, 1'b0, 1'b0, fetch_w(1'b0), "reset_state");
        rstn_i = 1'b1;
        zero_model();

        run_instr(OP_R, 0, 0, 0);
        run_instr(OP_L, 0, 3, 0);
        perf_check("perf_r_ld");
        run_instr(OP_R, 5, 0, 0);
        run_instr(OP_R, 4, 0, 0);
        run_instr(7'b1111111, 0, 0, 0);
        run_instr(OP_S, 0, 4, 2);
        run_instr(OP_L, 1, 5, 0);
        run_instr(OP_JALR, 0, 0, 0);
        perf_check("perf_directed");
        reset_mid_write();
        perf_check("perf_after_reset");
        run_instr(OP_JAL, 4, 0, 0);

        for (int n = 0; n < 80; n++) begin
            int k;
            logic [6:0] op;
            k = $urandom_range(0, 9);
            if (k == 9) begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
            end else begin
                op = ops[k];
            end
            run_instr(op, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 2));
        end
        perf_check("perf_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
